// File: rtl/detect_head_sched.sv
// detect_head_sched: issues the 18 detect-head conv jobs one at a time to a
// shared conv engine, chaining ping/pong scratch and placing final outputs.
module detect_head_sched #(
    parameter int IN_CH1 = 1,
    parameter int IN_CH2 = 1,
    parameter int IN_CH3 = 1,
    parameter int IN_H1  = 1,
    parameter int IN_H2  = 1,
    parameter int IN_H3  = 1,
    parameter int IN_W1  = 1,
    parameter int IN_W2  = 1,
    parameter int IN_W3  = 1,
    parameter int REG_CH = 64,
    parameter int CLS_CH = 80,
    parameter int OFF_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             job_valid,
    input  logic             job_ready,
    output logic [1:0]       job_scale,
    output logic             job_branch,
    output logic [1:0]       job_layer,
    output logic [15:0]      job_in_ch,
    output logic [15:0]      job_out_ch,
    output logic [15:0]      job_h,
    output logic [15:0]      job_w,
    output logic [1:0]       job_k,
    output logic             job_pad,
    output logic             job_mode,
    output logic [1:0]       job_src,
    output logic [1:0]       job_dst,
    output logic [OFF_W-1:0] job_dst_off,
    input  logic             eng_done,
    output logic             err_spurious
);

    localparam int OUT_CH = REG_CH + CLS_CH;
    localparam int A1     = IN_H1 * IN_W1;
    localparam int A2     = IN_H2 * IN_W2;
    localparam int A3     = IN_H3 * IN_W3;
    localparam int BASE2  = OUT_CH * A1;
    localparam int BASE3  = BASE2 + OUT_CH * A2;

    // Output offsets are fixed by the feature-map geometry.
    localparam logic [OFF_W-1:0] OFF_1R = '0;
    localparam logic [OFF_W-1:0] OFF_1C = OFF_W'(REG_CH * A1);
    localparam logic [OFF_W-1:0] OFF_2R = OFF_W'(BASE2);
    localparam logic [OFF_W-1:0] OFF_2C = OFF_W'(BASE2 + REG_CH * A2);
    localparam logic [OFF_W-1:0] OFF_3R = OFF_W'(BASE3);
    localparam logic [OFF_W-1:0] OFF_3C = OFF_W'(BASE3 + REG_CH * A3);

    localparam logic [15:0] CH1   = 16'(IN_CH1);
    localparam logic [15:0] CH2   = 16'(IN_CH2);
    localparam logic [15:0] CH3   = 16'(IN_CH3);
    localparam logic [15:0] H1    = 16'(IN_H1);
    localparam logic [15:0] H2    = 16'(IN_H2);
    localparam logic [15:0] H3    = 16'(IN_H3);
    localparam logic [15:0] W1    = 16'(IN_W1);
    localparam logic [15:0] W2    = 16'(IN_W2);
    localparam logic [15:0] W3    = 16'(IN_W3);
    localparam logic [15:0] RCH   = 16'(REG_CH);
    localparam logic [15:0] CCH   = 16'(CLS_CH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [4:0] idx_q, idx_d;
    logic [1:0] scale_q, scale_d;
    logic       branch_q, branch_d;
    logic [1:0] layer_q, layer_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic valid_q, valid_d;
    logic err_q, err_d;

    logic [1:0]       job_scale_q, job_scale_d;
    logic             job_branch_q, job_branch_d;
    logic [1:0]       job_layer_q, job_layer_d;
    logic [15:0]      job_in_ch_q, job_in_ch_d;
    logic [15:0]      job_out_ch_q, job_out_ch_d;
    logic [15:0]      job_h_q, job_h_d;
    logic [15:0]      job_w_q, job_w_d;
    logic [1:0]       job_k_q, job_k_d;
    logic             job_pad_q, job_pad_d;
    logic             job_mode_q, job_mode_d;
    logic [1:0]       job_src_q, job_src_d;
    logic [1:0]       job_dst_q, job_dst_d;
    logic [OFF_W-1:0] job_off_q, job_off_d;

    logic last;
    logic accept_start;
    logic advance;
    logic active;

    logic [15:0]      sc_in_ch;
    logic [15:0]      sc_h;
    logic [15:0]      sc_w;
    logic [OFF_W-1:0] sc_off_r;
    logic [OFF_W-1:0] sc_off_c;
    logic [15:0]      br_ch;

    assign last         = (idx_q == 5'd17);
    assign accept_start = (state_q == S_IDLE) && start;
    assign advance      = (state_q == S_WAIT) && eng_done && !last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: if (job_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done) begin
                    state_d = last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Job index walks layer, then branch, then scale.
    always_comb begin
        idx_d    = idx_q;
        scale_d  = scale_q;
        branch_d = branch_q;
        layer_d  = layer_q;
        if (accept_start || state_q == S_DONE) begin
            idx_d    = '0;
            scale_d  = '0;
            branch_d = 1'b0;
            layer_d  = '0;
        end else if (advance) begin
            idx_d = idx_q + 5'd1;
            if (layer_q == 2'd2) begin
                layer_d = '0;
                if (branch_q) begin
                    branch_d = 1'b0;
                    scale_d  = scale_q + 2'd1;
                end else begin
                    branch_d = 1'b1;
                end
            end else begin
                layer_d = layer_q + 2'd1;
            end
        end
    end

    always_comb begin
        sc_in_ch = '0;
        sc_h     = '0;
        sc_w     = '0;
        sc_off_r = '0;
        sc_off_c = '0;
        unique case (scale_d)
            2'd0: begin
                sc_in_ch = CH1;
                sc_h     = H1;
                sc_w     = W1;
                sc_off_r = OFF_1R;
                sc_off_c = OFF_1C;
            end
            2'd1: begin
                sc_in_ch = CH2;
                sc_h     = H2;
                sc_w     = W2;
                sc_off_r = OFF_2R;
                sc_off_c = OFF_2C;
            end
            2'd2: begin
                sc_in_ch = CH3;
                sc_h     = H3;
                sc_w     = W3;
                sc_off_r = OFF_3R;
                sc_off_c = OFF_3C;
            end
            default: begin
                sc_in_ch = '0;
            end
        endcase
    end

    assign br_ch  = branch_d ? CCH : RCH;
    assign active = (state_d == S_ISSUE) || (state_d == S_WAIT);

    // Output logic: registered descriptor follows the next job index.
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        valid_d      = (state_d == S_ISSUE);
        job_scale_d  = '0;
        job_branch_d = 1'b0;
        job_layer_d  = '0;
        job_in_ch_d  = '0;
        job_out_ch_d = '0;
        job_h_d      = '0;
        job_w_d      = '0;
        job_k_d      = '0;
        job_pad_d    = 1'b0;
        job_mode_d   = 1'b0;
        job_src_d    = '0;
        job_dst_d    = '0;
        job_off_d    = '0;
        if (active) begin
            job_scale_d  = scale_d;
            job_branch_d = branch_d;
            job_layer_d  = layer_d;
            job_in_ch_d  = (layer_d == 2'd0) ? sc_in_ch : br_ch;
            job_out_ch_d = br_ch;
            job_h_d      = sc_h;
            job_w_d      = sc_w;
            job_k_d      = (layer_d == 2'd2) ? 2'd1 : 2'd3;
            job_pad_d    = (layer_d != 2'd2);
            job_mode_d   = (layer_d == 2'd2);
            job_src_d    = layer_d;
            job_dst_d    = layer_d + 2'd1;
            if (layer_d == 2'd2) begin
                job_off_d = branch_d ? sc_off_c : sc_off_r;
            end
        end
    end

    // A completion is only legitimate while a job is outstanding.
    always_comb begin
        err_d = err_q;
        if (accept_start) err_d = 1'b0;
        if (eng_done && state_q != S_WAIT) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            scale_q      <= '0;
            branch_q     <= 1'b0;
            layer_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            job_scale_q  <= '0;
            job_branch_q <= 1'b0;
            job_layer_q  <= '0;
            job_in_ch_q  <= '0;
            job_out_ch_q <= '0;
            job_h_q      <= '0;
            job_w_q      <= '0;
            job_k_q      <= '0;
            job_pad_q    <= 1'b0;
            job_mode_q   <= 1'b0;
            job_src_q    <= '0;
            job_dst_q    <= '0;
            job_off_q    <= '0;
        end else begin
            idx_q        <= idx_d;
            scale_q      <= scale_d;
            branch_q     <= branch_d;
            layer_q      <= layer_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            job_scale_q  <= job_scale_d;
            job_branch_q <= job_branch_d;
            job_layer_q  <= job_layer_d;
            job_in_ch_q  <= job_in_ch_d;
            job_out_ch_q <= job_out_ch_d;
            job_h_q      <= job_h_d;
            job_w_q      <= job_w_d;
            job_k_q      <= job_k_d;
            job_pad_q    <= job_pad_d;
            job_mode_q   <= job_mode_d;
            job_src_q    <= job_src_d;
            job_dst_q    <= job_dst_d;
            job_off_q    <= job_off_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign job_valid    = valid_q;
    assign err_spurious = err_q;
    assign job_scale    = job_scale_q;
    assign job_branch   = job_branch_q;
    assign job_layer    = job_layer_q;
    assign job_in_ch    = job_in_ch_q;
    assign job_out_ch   = job_out_ch_q;
    assign job_h        = job_h_q;
    assign job_w        = job_w_q;
    assign job_k        = job_k_q;
    assign job_pad      = job_pad_q;
    assign job_mode     = job_mode_q;
    assign job_src      = job_src_q;
    assign job_dst      = job_dst_q;
    assign job_dst_off  = job_off_q;

endmodule

// File: tb/tb_detect_head_sched.sv
// tb_detect_head_sched: randomized engine model with a descriptor
// scoreboard for the detect-head job scheduler.
module tb_detect_head_sched;

    localparam int OFF_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic             job_valid;
    logic             job_ready = 1'b0;
    logic [1:0]       job_scale;
    logic             job_branch;
    logic [1:0]       job_layer;
    logic [15:0]      job_in_ch;
    logic [15:0]      job_out_ch;
    logic [15:0]      job_h;
    logic [15:0]      job_w;
    logic [1:0]       job_k;
    logic             job_pad;
    logic             job_mode;
    logic [1:0]       job_src;
    logic [1:0]       job_dst;
    logic [OFF_W-1:0] job_dst_off;
    logic             eng_done = 1'b0;
    logic             err_spurious;

    always #5 clk = ~clk;

    detect_head_sched #(
        .IN_CH1(8), .IN_CH2(16), .IN_CH3(32),
        .IN_H1(4), .IN_H2(2), .IN_H3(1),
        .IN_W1(4), .IN_W2(2), .IN_W3(1),
        .REG_CH(4), .CLS_CH(2), .OFF_W(OFF_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_scale(job_scale), .job_branch(job_branch),
        .job_layer(job_layer), .job_in_ch(job_in_ch),
        .job_out_ch(job_out_ch), .job_h(job_h), .job_w(job_w),
        .job_k(job_k), .job_pad(job_pad), .job_mode(job_mode),
        .job_src(job_src), .job_dst(job_dst),
        .job_dst_off(job_dst_off), .eng_done(eng_done),
        .err_spurious(err_spurious)
    );

    typedef struct packed {
        logic [1:0]  scale;
        logic        branch;
        logic [1:0]  layer;
        logic [15:0] in_ch;
        logic [15:0] out_ch;
        logic [15:0] h;
        logic [15:0] w;
        logic [1:0]  k;
        logic        pad;
        logic        mode;
        logic [1:0]  src;
        logic [1:0]  dst;
        logic [31:0] off;
    } job_t;

    job_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    // engine-model controls
    int lat_cfg = 3;
    bit rand_lat = 0;
    int cnt = 0;
    int acc_n = 0;
    int stall_idx = -1;
    int stall_rem = 0;
    bit inj_req = 0;
    int fire_cyc = -10;
    int fire_job = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: descriptor of job idx from the head's geometry.
    function automatic job_t model(int idx);
        int ich[3] = '{8, 16, 32};
        int hh[3]  = '{4, 2, 1};
        int ww[3]  = '{4, 2, 1};
        int srct[3] = '{0, 1, 2};
        int dstt[3] = '{1, 2, 3};
        int reg_ch = 4;
        int cls_ch = 2;
        int s = idx / 6;
        int b = (idx / 3) % 2;
        int l = idx % 3;
        int base = 0;
        int bch;
        job_t m;
        for (int i = 0; i < s; i++) base += (reg_ch + cls_ch) * hh[i] * ww[i];
        bch = b ? cls_ch : reg_ch;
        m.scale  = 2'(s);
        m.branch = 1'(b);
        m.layer  = 2'(l);
        m.in_ch  = 16'((l == 0) ? ich[s] : bch);
        m.out_ch = 16'(bch);
        m.h      = 16'(hh[s]);
        m.w      = 16'(ww[s]);
        m.k      = (l == 2) ? 2'd1 : 2'd3;
        m.pad    = (l != 2);
        m.mode   = (l == 2);
        m.src    = 2'(srct[l]);
        m.dst    = 2'(dstt[l]);
        m.off    = (l == 2) ? 32'(base + b * reg_ch * hh[s] * ww[s]) : 32'd0;
        return m;
    endfunction

    function automatic job_t cur();
        job_t c;
        c.scale  = job_scale;
        c.branch = job_branch;
        c.layer  = job_layer;
        c.in_ch  = job_in_ch;
        c.out_ch = job_out_ch;
        c.h      = job_h;
        c.w      = job_w;
        c.k      = job_k;
        c.pad    = job_pad;
        c.mode   = job_mode;
        c.src    = job_src;
        c.dst    = job_dst;
        c.off    = job_dst_off;
        return c;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_job(string name, job_t act, job_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine: accepts descriptors, optionally stalls, completes after a latency.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
                eng_done = 1'b0;
                job_ready = 1'b0;
                acc_n = 0;
                inj_req = 0;
            end else begin
                eng_done = inj_req;
                inj_req = 0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        eng_done = 1'b1;
                        fire_cyc = cyc;
                        fire_job = acc_n - 1;
                    end
                end
                if (job_valid && acc_n == stall_idx && stall_rem > 0) begin
                    job_ready = 1'b0;
                    stall_rem--;
                end else begin
                    job_ready = 1'b1;
                end
                if (job_valid && job_ready) begin
                    acc_n++;
                    cnt = rand_lat ? int'($urandom_range(1, 5)) : lat_cfg;
                end
            end
        end
    end

    // Monitor: compares presented descriptors and completion timing.
    initial begin
        job_t e;
        bit prev_done = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (job_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_job", 64'(1), 64'(0));
                    end else if (job_ready) begin
                        e = exp_q.pop_front();
                        check_job("job", cur(), e);
                    end else begin
                        check_job("held_job", cur(), exp_q[0]);
                    end
                end
                if (cyc == fire_cyc + 1) begin
                    if (fire_job < 17) check("next_valid", 64'(job_valid), 64'(1));
                    else check("done_latency", 64'(done), 64'(1));
                end
                if (done) begin
                    done_cnt++;
                    check("queue_drained", 64'(exp_q.size()), 64'(0));
                    check("busy_at_done", 64'(busy), 64'(1));
                    check("err_in_run", 64'(err_spurious), 64'(0));
                end
                if (prev_done) begin
                    check("busy_low", 64'(busy), 64'(0));
                    check("done_once", 64'(done), 64'(0));
                end
                prev_done = done;
            end else begin
                prev_done = 0;
            end
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1;
        acc_n = 0;
        for (int i = 0; i < 18; i++) exp_q.push_back(model(i));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_valid", 64'(job_valid), 64'(1));
        check("start_busy", 64'(busy), 64'(1));
        check("start_clr_err", 64'(err_spurious), 64'(0));
    endtask

    task automatic wait_done();
        int t = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt == d0) check("done_timeout", 64'(0), 64'(1));
        repeat (3) @(posedge clk);
    endtask

    task automatic check_idle_outputs(string name);
        job_t z;
        z = '0;
        check_job(name, cur(), z);
        check({name, "_ctl"}, 64'({busy, done, job_valid, err_spurious}), 64'(0));
    endtask

    initial begin
        int t;
        #12;
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // nominal run, fixed latency 3
        rand_lat = 0;
        lat_cfg = 3;
        do_start();
        wait_done();

        // random latency, job 4 stalled, start pulse mid-run
        rand_lat = 1;
        stall_idx = 4;
        stall_rem = 5;
        do_start();
        t = 0;
        while (!(acc_n == 4 && job_valid && !job_ready) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("stall_reached", 64'(t < 2000), 64'(1));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        check("stall_consumed", 64'(stall_rem), 64'(0));
        stall_idx = -1;

        // spurious completion while idle
        @(posedge clk);
        #1 inj_req = 1;
        repeat (2) @(posedge clk);
        #1;
        check("spurious_err", 64'(err_spurious), 64'(1));
        check("spurious_no_job", 64'({job_valid, busy}), 64'(0));
        do_start();
        wait_done();

        // reset during WAIT of job 9
        rand_lat = 0;
        lat_cfg = 4;
        do_start();
        t = 0;
        while (!(acc_n == 10 && !job_valid && busy) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("wait9_reached", 64'(t < 2000), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_start();
        wait_done();

        // a few randomized runs with random stalls
        rand_lat = 1;
        for (int r = 0; r < 3; r++) begin
            stall_idx = int'($urandom_range(0, 17));
            stall_rem = int'($urandom_range(1, 4));
            do_start();
            wait_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
